// File: rtl/register_file_pkg.sv
// Shared register-file constants: enable encodings, index width and zero word,
// plus a small helper used by the write and read paths.
`ifndef REGISTER_FILE_DEFINES
`define REGISTER_FILE_DEFINES
`define RESET_ENABLE    1'b0
`define WRITE_ENABLE    1'b1
`define WRITE_DISABLE   1'b0
`define READ_ENABLE     1'b1
`define READ_DISABLE    1'b0
`define REG_INDEX_WIDTH 5
`define ZERO_WORD       '0
`endif

package register_file_pkg;

  localparam int unsigned REG_INDEX_W = `REG_INDEX_WIDTH;

  typedef logic [REG_INDEX_W-1:0] reg_index_t;

  // Index 0 is the hardwired zero register and never holds state.
  function automatic logic is_zero_index(input reg_index_t index);
    return index == '0;
  endfunction

endpackage

// File: rtl/register_file_reg_read_port.sv
// One combinational read port: reset, enable, zero-register, then same-cycle
// write-through bypass, otherwise the stored entry.
import register_file_pkg::*;

module reg_read_port #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  reset,
  input  logic                  read_enable,
  input  reg_index_t            read_address,
  input  logic                  write_enable,
  input  reg_index_t            write_address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [DATA_WIDTH-1:0] entry_data,
  output logic [DATA_WIDTH-1:0] read_data
);

  always_comb begin
    read_data = `ZERO_WORD;
    if (reset == `RESET_ENABLE) begin
      read_data = `ZERO_WORD;
    end else if (read_enable == `READ_DISABLE) begin
      read_data = `ZERO_WORD;
    end else if (is_zero_index(read_address)) begin
      read_data = `ZERO_WORD;
    end else if (write_enable == `WRITE_ENABLE && write_address == read_address) begin
      read_data = write_data;
    end else begin
      read_data = entry_data;
    end
  end

endmodule

// File: rtl/register_file.sv
// Architectural register file: flop storage with async clear, two bypassing
// read ports and an unbypassed debug observation port.
import register_file_pkg::*;

module register_file #(
  parameter int unsigned REG_COUNT  = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        write_enable,
  input  logic [`REG_INDEX_WIDTH-1:0] write_address,
  input  logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        read_enable_1,
  input  logic [`REG_INDEX_WIDTH-1:0] read_address_1,
  output logic [DATA_WIDTH-1:0]       read_data_1,
  input  logic                        read_enable_2,
  input  logic [`REG_INDEX_WIDTH-1:0] read_address_2,
  output logic [DATA_WIDTH-1:0]       read_data_2,
  input  logic [`REG_INDEX_WIDTH-1:0] debug_address,
  output logic [DATA_WIDTH-1:0]       debug_data
);

  logic [DATA_WIDTH-1:0] entries [REG_COUNT];
  logic [DATA_WIDTH-1:0] entry_1;
  logic [DATA_WIDTH-1:0] entry_2;

  always_ff @(posedge clock or negedge reset) begin
    if (reset == `RESET_ENABLE) begin
      for (int i = 0; i < int'(REG_COUNT); i++) begin
        entries[i] <= `ZERO_WORD;
      end
    end else if (write_enable == `WRITE_ENABLE && !is_zero_index(write_address)
                 && 32'(write_address) < REG_COUNT) begin
      entries[write_address] <= write_data;
    end
  end

  // Out-of-range indices (only possible with REG_COUNT < 32) read as zero.
  always_comb begin
    entry_1 = `ZERO_WORD;
    entry_2 = `ZERO_WORD;
    if (32'(read_address_1) < REG_COUNT) entry_1 = entries[read_address_1];
    if (32'(read_address_2) < REG_COUNT) entry_2 = entries[read_address_2];
  end

  reg_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_read_port_1 (
    .reset         (reset),
    .read_enable   (read_enable_1),
    .read_address  (read_address_1),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .entry_data    (entry_1),
    .read_data     (read_data_1)
  );

  reg_read_port #(.DATA_WIDTH(DATA_WIDTH)) u_read_port_2 (
    .reset         (reset),
    .read_enable   (read_enable_2),
    .read_address  (read_address_2),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .entry_data    (entry_2),
    .read_data     (read_data_2)
  );

  always_comb begin
    debug_data = `ZERO_WORD;
    if (reset != `RESET_ENABLE && !is_zero_index(debug_address)
        && 32'(debug_address) < REG_COUNT) begin
      debug_data = entries[debug_address];
    end
  end

endmodule
